// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared loader constants, default widths and FSM state encoding.
package arch_defs_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR_HI, ST_ADDR_LO, ST_LEN, ST_DATA, ST_CHK, ST_DONE
    } loader_state_e;
endpackage

// File: rtl/mem_loader.sv
// mem_loader: receives SYNC/ADDR/LEN/DATA/CHK frames and writes the payload into RAM,
// holding the CPU in reset while a frame is in flight.
module mem_loader
    import arch_defs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);
    loader_state_e state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [7:0] chk_q, chk_d, byte_in, sum;
    logic mem_we_q, mem_we_d, cpu_hold_q, cpu_hold_d;
    logic load_done_q, load_done_d, load_error_q, load_error_d;
    logic accept;

    assign rx_ready = state_q != ST_DONE;
    assign accept = rx_valid && rx_ready;
    assign byte_in = rx_data[7:0];
    assign sum = chk_q + byte_in;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        chk_d = chk_q;
        mem_we_d = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        cpu_hold_d = cpu_hold_q;
        load_done_d = 1'b0;
        load_error_d = load_error_q;
        if (accept) begin
            // SYNC is excluded from the checksum; every later byte adds in
            if (state_q != ST_IDLE) chk_d = sum;
            case (state_q)
                ST_IDLE: if (byte_in == LOADER_SYNC) begin
                    state_d = ST_ADDR_HI;
                    chk_d = 8'h00;
                    cpu_hold_d = 1'b1;
                    load_error_d = 1'b0;
                end
                ST_ADDR_HI: begin
                    addr_d = ADDR_WIDTH'(byte_in);
                    state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    addr_d = ADDR_WIDTH'({addr_q[7:0], byte_in});
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    cnt_d = (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    mem_we_d = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = rx_data;
                    addr_d = addr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    state_d = (cnt_q == 9'd1) ? ST_CHK : ST_DATA;
                end
                ST_CHK: begin
                    state_d = ST_DONE;
                    load_error_d = load_error_q | (sum != 8'h00);
                    load_done_d = sum == 8'h00;
                end
                default: ;
            endcase
        end
        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
            cpu_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            chk_q <= '0;
            mem_we_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_hold_q <= 1'b0;
            load_done_q <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            chk_q <= chk_d;
            mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_hold_q <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign mem_we = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign cpu_hold = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_error = load_error_q;
endmodule
